// File: rtl/config_pkg.sv
// Shared types and sizing helpers for the configuration frame loader.
package config_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    SHIFT = 3'd2,
    CHECK = 3'd3,
    LATCH = 3'd4,
    DONE  = 3'd5,
    ERROR = 3'd6
  } state_t;

  function automatic int nwords(input int chain_len, input int word_w);
    return (chain_len + word_w - 1) / word_w;
  endfunction

  function automatic int last_bits(input int chain_len, input int word_w);
    return chain_len - (nwords(chain_len, word_w) - 1) * word_w;
  endfunction

  // Width of a counter that must hold values 0..n-1 (never narrower than 1).
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/config_load_ctrl_if.sv
// Loader-to-controller word handshake.
interface config_load_ctrl_if #(parameter int WORD_W = 8);
  // A word transfers on the rising clk edge where in_valid && in_ready are both
  // high; the master holds in_data stable while in_valid is high and unaccepted.
  logic [WORD_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/config_piso.sv
// Parallel-in/serial-out word register; emits bit 0 first and flags the last bit.
module config_piso #(
    parameter int WORD_W = 8,
    parameter int LEN_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              shift,
    input  logic [WORD_W-1:0] data,
    input  logic [LEN_W-1:0]  len,
    output logic              bit_out,
    output logic              last
);

    logic [WORD_W-1:0] sr;
    logic [LEN_W-1:0]  cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            sr  <= '0;
            cnt <= '0;
        end else if (load) begin
            sr  <= data;
            cnt <= '0;
        end else if (shift) begin
            sr  <= sr >> 1;
            cnt <= cnt + LEN_W'(1);
        end
    end

    assign bit_out = sr[0];
    assign last    = (cnt == len - LEN_W'(1));

endmodule

// File: rtl/config_load_ctrl.sv
// Config frame loader: serialises host words onto the shift chain, then strobes set.
// Optional CONFIG_CHECK_EN adds an XOR check word before commit.
module config_load_ctrl
    import config_pkg::*;
#(
    parameter int WORD_W     = 8,
    parameter int CHAIN_LEN  = 64,
    parameter int SET_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    config_load_ctrl_if.slave  ld,
    output logic               shift_en,
    output logic               shift_out,
    output logic               set,
    output logic               busy,
    output logic               done,
    output logic               error,
    output state_t             dbg_state
);

    localparam int NWORDS    = nwords(CHAIN_LEN, WORD_W);
    localparam int LAST_BITS = last_bits(CHAIN_LEN, WORD_W);
    localparam int WC_W      = cnt_w(NWORDS);
    localparam int ST_W      = cnt_w(SET_CYCLES);
    localparam int LEN_W     = cnt_w(WORD_W + 1);

    state_t            state;
    logic              in_ready_q;
    logic              err_q;
    logic [WC_W-1:0]   word_cnt;
    logic [ST_W-1:0]   set_cnt;
    logic              last_word;
    logic              piso_load;
    logic              piso_bit;
    logic              piso_last;
    logic [LEN_W-1:0]  piso_len;

`ifdef CONFIG_CHECK_EN
    localparam logic [WORD_W-1:0] LAST_MASK = {WORD_W{1'b1}} >> (WORD_W - LAST_BITS);
    logic [WORD_W-1:0] csum;
`endif

    assign last_word = (word_cnt == WC_W'(NWORDS - 1));
    assign piso_len  = last_word ? LEN_W'(LAST_BITS) : LEN_W'(WORD_W);
    assign piso_load = (state == LOAD) && ld.in_valid && !abort;

    config_piso #(.WORD_W(WORD_W), .LEN_W(LEN_W)) u_piso (
        .clk     (clk),
        .rst     (rst),
        .load    (piso_load),
        .shift   (shift_en),
        .data    (ld.in_data),
        .len     (piso_len),
        .bit_out (piso_bit),
        .last    (piso_last)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            in_ready_q <= 1'b0;
            shift_en   <= 1'b0;
            set        <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err_q      <= 1'b0;
            word_cnt   <= '0;
            set_cnt    <= '0;
`ifdef CONFIG_CHECK_EN
            csum       <= '0;
`endif
        end else begin
            case (state)
                IDLE, DONE, ERROR: begin
                    if (start && !abort) begin
                        state      <= LOAD;
                        in_ready_q <= 1'b1;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        err_q      <= 1'b0;
                        word_cnt   <= '0;
`ifdef CONFIG_CHECK_EN
                        csum       <= '0;
`endif
                    end
                end
                LOAD: begin
                    if (abort) begin
                        state      <= IDLE;
                        in_ready_q <= 1'b0;
                        busy       <= 1'b0;
                    end else if (ld.in_valid) begin
                        state      <= SHIFT;
                        in_ready_q <= 1'b0;
                        shift_en   <= 1'b1;
`ifdef CONFIG_CHECK_EN
                        csum       <= csum ^ (last_word ? (ld.in_data & LAST_MASK) : ld.in_data);
`endif
                    end
                end
                SHIFT: begin
                    if (abort) begin
                        state    <= IDLE;
                        shift_en <= 1'b0;
                        busy     <= 1'b0;
                    end else if (piso_last) begin
                        shift_en <= 1'b0;
                        if (last_word) begin
`ifdef CONFIG_CHECK_EN
                            state      <= CHECK;
                            in_ready_q <= 1'b1;
`else
                            state   <= LATCH;
                            set     <= 1'b1;
                            set_cnt <= '0;
`endif
                        end else begin
                            state      <= LOAD;
                            in_ready_q <= 1'b1;
                            word_cnt   <= word_cnt + WC_W'(1);
                        end
                    end
                end
`ifdef CONFIG_CHECK_EN
                CHECK: begin
                    if (abort) begin
                        state      <= IDLE;
                        in_ready_q <= 1'b0;
                        busy       <= 1'b0;
                    end else if (ld.in_valid) begin
                        in_ready_q <= 1'b0;
                        if (ld.in_data == csum) begin
                            state   <= LATCH;
                            set     <= 1'b1;
                            set_cnt <= '0;
                        end else begin
                            state <= ERROR;
                            err_q <= 1'b1;
                            busy  <= 1'b0;
                        end
                    end
                end
`endif
                LATCH: begin
                    // abort is deliberately ignored: a started commit always completes
                    if (set_cnt == ST_W'(SET_CYCLES - 1)) begin
                        set   <= 1'b0;
                        state <= DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end else begin
                        set_cnt <= set_cnt + ST_W'(1);
                    end
                end
                default: begin
                    state      <= IDLE;
                    in_ready_q <= 1'b0;
                    shift_en   <= 1'b0;
                    set        <= 1'b0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

    assign ld.in_ready = in_ready_q;
    assign shift_out   = shift_en & piso_bit;
    assign error       = err_q;
    assign dbg_state   = state;

endmodule

// File: tb/tb_config_load_ctrl.sv
// Self-checking bench for config_load_ctrl (CHAIN_LEN=20 and CHAIN_LEN=5 instances).
module tb_config_load_ctrl;
  import config_pkg::*;

  localparam int W   = 8;
  localparam int LA  = 20;
  localparam int LB  = 5;
  localparam int SC  = 2;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic   start_a = 1'b0, abort_a = 1'b0;
  logic   sh_en_a, sh_out_a, set_a, busy_a, done_a, err_a;
  state_t st_a;
  logic   start_b = 1'b0, abort_b = 1'b0;
  logic   sh_en_b, sh_out_b, set_b, busy_b, done_b, err_b;
  state_t st_b;

  config_load_ctrl_if #(.WORD_W(W)) ifa ();
  config_load_ctrl_if #(.WORD_W(W)) ifb ();

  config_load_ctrl #(.WORD_W(W), .CHAIN_LEN(LA), .SET_CYCLES(SC)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .abort(abort_a), .ld(ifa.slave),
    .shift_en(sh_en_a), .shift_out(sh_out_a), .set(set_a), .busy(busy_a),
    .done(done_a), .error(err_a), .dbg_state(st_a)
  );

  config_load_ctrl #(.WORD_W(W), .CHAIN_LEN(LB), .SET_CYCLES(SC)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .abort(abort_b), .ld(ifb.slave),
    .shift_en(sh_en_b), .shift_out(sh_out_b), .set(set_b), .busy(busy_b),
    .done(done_b), .error(err_b), .dbg_state(st_b)
  );

  // scoreboard
  logic [0:0] exp_qa[$];
  logic [0:0] exp_qb[$];
  int n_checks = 0;
  int n_pass = 0;
  int shifts_a = 0, sets_a = 0, ready_bad_a = 0;
  int shifts_b = 0, sets_b = 0;
  logic [0:0] eb_a, eb_b;

  always @(negedge clk) begin
    if (sh_en_a) begin
      shifts_a++;
      n_checks++;
      if (exp_qa.size() == 0) begin
        $display("FAIL shift_a: unexpected bit %0b with empty expected queue", sh_out_a);
      end else begin
        eb_a = exp_qa.pop_front();
        if (sh_out_a !== eb_a[0]) $display("FAIL shift_a: got %0b want %0b", sh_out_a, eb_a[0]);
        else n_pass++;
      end
    end
    if (sh_en_b) begin
      shifts_b++;
      n_checks++;
      if (exp_qb.size() == 0) begin
        $display("FAIL shift_b: unexpected bit %0b with empty expected queue", sh_out_b);
      end else begin
        eb_b = exp_qb.pop_front();
        if (sh_out_b !== eb_b[0]) $display("FAIL shift_b: got %0b want %0b", sh_out_b, eb_b[0]);
        else n_pass++;
      end
    end
    if (set_a) sets_a++;
    if (set_b) sets_b++;
    if (ifa.in_ready && (st_a != LOAD) && (st_a != CHECK)) ready_bad_a++;
    if (ifa.in_ready && (sh_en_a || set_a)) ready_bad_a++;
  end

  // driver tasks
  task automatic pulse_start_a();
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
  endtask

  task automatic pulse_start_b();
    start_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
  endtask

  task automatic send_a(input logic [W-1:0] w, input int nbits, input bit tog);
    int g = 0;
    bit acc = 1'b0;
    bit v;
    for (int i = 0; i < nbits; i++) exp_qa.push_back(w[i]);
    while (!acc && g < 100) begin
      v = tog ? bit'(g % 2) : 1'b1;
      ifa.in_valid = v;
      ifa.in_data  = v ? w : W'($urandom);
      acc = v && ifa.in_ready;
      @(posedge clk); #1;
      g++;
    end
    ifa.in_valid = 1'b0;
    if (!acc) begin
      n_checks++;
      $display("FAIL send_a: word %h not accepted within 100 cycles", w);
    end
  endtask

  task automatic send_b(input logic [W-1:0] w, input int nbits);
    int g = 0;
    bit acc = 1'b0;
    for (int i = 0; i < nbits; i++) exp_qb.push_back(w[i]);
    while (!acc && g < 100) begin
      ifb.in_valid = 1'b1;
      ifb.in_data  = w;
      acc = ifb.in_ready;
      @(posedge clk); #1;
      g++;
    end
    ifb.in_valid = 1'b0;
    if (!acc) begin
      n_checks++;
      $display("FAIL send_b: word %h not accepted within 100 cycles", w);
    end
  endtask

  task automatic send_frame_a(input bit tog, input logic [W-1:0] chk);
    send_a(8'hA5, 8, tog);
    send_a(8'h3C, 8, tog);
    send_a(8'h0F, 4, tog);
`ifdef CONFIG_CHECK_EN
    send_a(chk, 0, tog);
`else
    if (chk === 8'hxx) $display("note: unused check word");
`endif
  endtask

  task automatic wait_end_a();
    int g = 0;
    while (!(done_a || err_a) && g < 100) begin
      @(posedge clk); #1;
      g++;
    end
    if (!(done_a || err_a)) begin
      n_checks++;
      $display("FAIL wait_end_a: no done/error within 100 cycles");
    end
  endtask

  task automatic wait_end_b();
    int g = 0;
    while (!(done_b || err_b) && g < 100) begin
      @(posedge clk); #1;
      g++;
    end
    if (!(done_b || err_b)) begin
      n_checks++;
      $display("FAIL wait_end_b: no done/error within 100 cycles");
    end
  endtask

  // scenarios
  task automatic test_reset();
    rst = 1'b0;
    ifa.in_valid = 1'b0; ifa.in_data = '0;
    ifb.in_valid = 1'b0; ifb.in_data = '0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (st_a !== IDLE) $display("FAIL reset_state_a: got %0d want %0d", st_a, IDLE);
    else n_pass++;
    n_checks++;
    if ({ifa.in_ready, sh_en_a, sh_out_a, set_a, busy_a, done_a, err_a} !== 7'b0)
      $display("FAIL reset_outs_a: got %b want 0000000",
               {ifa.in_ready, sh_en_a, sh_out_a, set_a, busy_a, done_a, err_a});
    else n_pass++;
    n_checks++;
    if ({ifb.in_ready, sh_en_b, sh_out_b, set_b, busy_b, done_b, err_b} !== 7'b0)
      $display("FAIL reset_outs_b: got %b want 0000000",
               {ifb.in_ready, sh_en_b, sh_out_b, set_b, busy_b, done_b, err_b});
    else n_pass++;
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_frame(input bit tog);
    shifts_a = 0; sets_a = 0; ready_bad_a = 0;
    pulse_start_a();
    n_checks++;
    if (busy_a !== 1'b1 || done_a !== 1'b0) $display("FAIL frame_start: busy=%0b done=%0b want 1 0", busy_a, done_a);
    else n_pass++;
    send_frame_a(tog, 8'h96);
    wait_end_a();
    n_checks++;
    if (shifts_a !== LA) $display("FAIL frame_shift_count: got %0d want %0d", shifts_a, LA);
    else n_pass++;
    n_checks++;
    if (sets_a !== SC) $display("FAIL frame_set_cycles: got %0d want %0d", sets_a, SC);
    else n_pass++;
    n_checks++;
    if ({done_a, busy_a, err_a} !== 3'b100) $display("FAIL frame_status: done/busy/err=%b want 100", {done_a, busy_a, err_a});
    else n_pass++;
    n_checks++;
    if (exp_qa.size() != 0) $display("FAIL frame_leftover: %0d bits not shifted, want 0", exp_qa.size());
    else n_pass++;
    if (tog) begin
      n_checks++;
      if (ready_bad_a != 0) $display("FAIL toggle_in_ready: %0d bad cycles want 0", ready_bad_a);
      else n_pass++;
    end
  endtask

  task automatic test_abort();
    shifts_a = 0; sets_a = 0;
    pulse_start_a();
    send_a(8'hA5, 8, 1'b0);
    send_a(8'h3C, 8, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    abort_a = 1'b1;
    @(posedge clk); #1;
    abort_a = 1'b0;
    n_checks++;
    if (st_a !== IDLE || sh_en_a !== 1'b0 || busy_a !== 1'b0 || done_a !== 1'b0)
      $display("FAIL abort_idle: state=%0d shift_en=%0b busy=%0b done=%0b want IDLE 0 0 0",
               st_a, sh_en_a, busy_a, done_a);
    else n_pass++;
    n_checks++;
    if (shifts_a !== 13) $display("FAIL abort_shift_count: got %0d want 13", shifts_a);
    else n_pass++;
    exp_qa.delete();
    repeat (5) @(posedge clk);
    #1;
    n_checks++;
    if (sets_a !== 0 || done_a !== 1'b0) $display("FAIL abort_no_commit: sets=%0d done=%0b want 0 0", sets_a, done_a);
    else n_pass++;
    test_frame(1'b0);
  endtask

  task automatic test_reset_latch();
    int g = 0;
    sets_a = 0;
    pulse_start_a();
    send_frame_a(1'b0, 8'h96);
    while (!set_a && g < 50) begin
      @(posedge clk); #1;
      g++;
    end
    if (!set_a) begin
      n_checks++;
      $display("FAIL reset_latch_wait: set never rose within 50 cycles");
    end
    rst = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if ({ifa.in_ready, sh_en_a, sh_out_a, set_a, busy_a, done_a, err_a} !== 7'b0 || st_a !== IDLE)
      $display("FAIL reset_latch_outs: outs=%b state=%0d want 0000000 IDLE",
               {ifa.in_ready, sh_en_a, sh_out_a, set_a, busy_a, done_a, err_a}, st_a);
    else n_pass++;
    rst = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    n_checks++;
    if (sets_a !== 1 || done_a !== 1'b0) $display("FAIL reset_latch_commit: sets=%0d done=%0b want 1 0", sets_a, done_a);
    else n_pass++;
  endtask

`ifdef CONFIG_CHECK_EN
  task automatic test_check();
    sets_a = 0;
    pulse_start_a();
    send_frame_a(1'b0, 8'h97);
    wait_end_a();
    n_checks++;
    if ({err_a, done_a, busy_a} !== 3'b100 || sets_a !== 0 || st_a !== ERROR)
      $display("FAIL check_bad: err/done/busy=%b sets=%0d state=%0d want 100 0 ERROR",
               {err_a, done_a, busy_a}, sets_a, st_a);
    else n_pass++;
    pulse_start_a();
    n_checks++;
    if (err_a !== 1'b0) $display("FAIL check_err_clear: got %0b want 0", err_a);
    else n_pass++;
    send_frame_a(1'b0, 8'h96);
    wait_end_a();
    n_checks++;
    if ({done_a, err_a} !== 2'b10 || sets_a !== SC)
      $display("FAIL check_good: done/err=%b sets=%0d want 10 %0d", {done_a, err_a}, sets_a, SC);
    else n_pass++;
  endtask
`endif

  task automatic test_short();
    shifts_b = 0; sets_b = 0;
    pulse_start_b();
    send_b(8'hFF, LB);
    start_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
    n_checks++;
    if (st_b !== SHIFT || busy_b !== 1'b1) $display("FAIL short_start_ignored: state=%0d busy=%0b want SHIFT 1", st_b, busy_b);
    else n_pass++;
`ifdef CONFIG_CHECK_EN
    send_b(8'h1F, 0);
`endif
    wait_end_b();
    n_checks++;
    if (shifts_b !== LB) $display("FAIL short_shift_count: got %0d want %0d", shifts_b, LB);
    else n_pass++;
    n_checks++;
    if ({done_b, busy_b, ifb.in_ready} !== 3'b100 || sets_b !== SC)
      $display("FAIL short_status: done/busy/ready=%b sets=%0d want 100 %0d",
               {done_b, busy_b, ifb.in_ready}, sets_b, SC);
    else n_pass++;
    n_checks++;
    if (exp_qb.size() != 0) $display("FAIL short_leftover: %0d bits want 0", exp_qb.size());
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_frame(1'b0);
    test_frame(1'b1);
    test_abort();
    test_reset_latch();
`ifdef CONFIG_CHECK_EN
    test_check();
`endif
    test_short();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/config_load_ctrl.md
Name: config_load_ctrl

Overview:
- Sequences loading of one configuration frame into the fabric's config shift chain, then commits it to the config latches.
- Accepts WORD_W-bit words from the host loader over a valid/ready handshake and serialises them LSB-first onto the chain (shift_out/shift_en).
- After CHAIN_LEN bits have been shifted, pulses set so the latch bank captures the parallel chain contents.
- Sits between the bitstream loader and the shift chain / latch bank.

Parameters:
- WORD_W, 8, width of host data words.
- CHAIN_LEN, 64, total config bits in the chain; any value ≥1, need not be a multiple of WORD_W.
- SET_CYCLES, 2, cycles set is held high during commit; ≥1.

Ports:
- clk  in  1  single clock; all state on posedge.
- rst  in  1  synchronous, active-low reset (rst==0 resets on the clock edge).
- start  in  1  begin a frame load; sampled only in IDLE.
- abort  in  1  cancel the load in progress; return to IDLE with no commit.
- in_data  in  WORD_W  config word from the loader.
- in_valid  in  1  in_data valid.
- in_ready  out  1  controller accepts a word this cycle.
- shift_en  out  1  chain shifts one bit this cycle.
- shift_out  out  1  serial bit into the chain; valid when shift_en=1.
- set  out  1  latch-commit strobe to the latch bank.
- busy  out  1  high in any state except IDLE/DONE/ERROR.
- done  out  1  frame committed; held until the next accepted start.
- error  out  1  check failure (CONFIG_CHECK_EN only); held until the next accepted start.

Behaviour:
- Reset (rst=0): state=IDLE; in_ready, shift_en, shift_out, set, busy, done, error all 0; bit counter 0. Reset is honoured in every state; a mid-load reset leaves the chain partially shifted and does not assert set.
- Frame size: NWORDS = ceil(CHAIN_LEN/WORD_W). The last word shifts only LAST_BITS = CHAIN_LEN - (NWORDS-1)*WORD_W low bits; its upper bits are ignored.
- IDLE: start=1 → LOAD. done and error clear on that edge.
- DONE and ERROR behave as IDLE for start.
- LOAD:
  - in_ready=1.
  - A word is accepted on a cycle where in_valid & in_ready; it is registered and the state moves to SHIFT.
  - in_valid low → wait indefinitely.
- SHIFT:
  - in_ready=0; shift_en=1 every cycle.
  - shift_out = bit k of the registered word, k = 0..n-1, where n = WORD_W, or LAST_BITS for the final word.
  - Throughput: word accepted at cycle t → shift_en high cycles t+1..t+n.
  - After bit n-1: more words remain → LOAD; else → LATCH (or CHECK when the feature is enabled).
- LATCH:
  - set=1 for exactly SET_CYCLES consecutive cycles; shift_en=0.
  - Then → DONE: done=1, busy=0.
- Total shift_en-high cycles per frame = CHAIN_LEN exactly.
- abort=1 in LOAD/SHIFT/CHECK → IDLE next edge: shift_en=0, set never asserted, done=0.
- abort in LATCH is ignored; the commit completes.
- start while busy is ignored.
- Simultaneous start and abort in IDLE: abort wins, stay IDLE.
- CHAIN_LEN < WORD_W: single word, LAST_BITS = CHAIN_LEN.

Optional Feature:
- Macro: CONFIG_CHECK_EN.
- Defined:
  - After the final data word, one extra check word is accepted in state CHECK.
  - Check word = XOR of all data words, with the last word masked to its LAST_BITS.
  - Match → LATCH.
  - Mismatch → ERROR: error=1, set never asserted, busy=0.
- Undefined: no CHECK state; error tied 0.

Decomposition:
- Shared package config_pkg holds:
  - state enum (IDLE, LOAD, SHIFT, CHECK, LATCH, DONE, ERROR);
  - NWORDS / LAST_BITS constant functions (ceil-div);
  - counter width helper ($clog2-based).
- One sub-module: config_piso, a WORD_W-bit parallel-in/serial-out register with load, shift and bit-count-done outputs. The FSM, word counter, set timer and checksum stay in config_load_ctrl.

Test Plan:
1. WORD_W=8, CHAIN_LEN=20, words 0xA5,0x3C,0x0F (check word 0x96 if enabled) → shift_out LSB-first = 1010_0101 0011_1100 then 1111 (low 4 bits of 0x0F); 20 shift_en cycles; set high 2 cycles; done=1, busy=0.
2. in_valid toggled 0/1 every other cycle → no word dropped or duplicated; shift_out bit sequence identical to test 1; in_ready high only in LOAD.
3. abort=1 on the 5th SHIFT cycle of word 2 → IDLE next edge; set never asserted; done=0. A new start then loads a full frame correctly.
4. rst=0 for 1 cycle mid-LATCH → all outputs 0 next edge; set drops immediately; state IDLE.
5. CONFIG_CHECK_EN, words as test 1, check word 0x97 → error=1, set never high, done=0. Resend with 0x96 → done=1, error cleared at start.
6. CHAIN_LEN=5, WORD_W=8, word 0xFF → exactly 5 shift_en cycles of 1; start asserted during SHIFT is ignored.
